// File: rtl/load_store_unit.sv
// Sub-word load/store adapter between EX/MEM and a word-only data memory.
// Big-endian lanes; byte/half stores use a two-cycle read-modify-write.
module load_store_unit (
  input  logic        Clk_i,
  input  logic        Rst_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] StoreData_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [1:0]  MemSize_i,
  input  logic        LoadUnsigned_i,
  output logic [31:0] LoadData_o,
  output logic        Stall_o,
  output logic        AddrError_o,
  output logic [15:0] RmwCount_o,
  output logic [31:0] DM_Address_o,
  output logic [31:0] DM_WriteData_o,
  output logic        DM_MemWrite_o,
  output logic        DM_MemRead_o,
  input  logic [31:0] DM_ReadData_i
);

  typedef enum logic {IDLE, RMW_WRITE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] merged_q, merged_d;
  logic [15:0] rmw_count_q, rmw_count_d;

  logic        is_half, is_byte, is_word, misaligned;
  logic [31:0] merged, load_ext;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign is_half    = (MemSize_i == 2'b01);
  assign is_byte    = (MemSize_i == 2'b10);
  assign is_word    = !is_half && !is_byte;
  assign misaligned = (MemRead_i || MemWrite_i) &&
                      ((is_half && Address_i[0]) || (is_word && (Address_i[1:0] != 2'b00)));

  // Lane select and merge; address 0 is the most significant byte.
  always_comb begin
    merged = DM_ReadData_i;
    lane_b = DM_ReadData_i[7:0];
    case (Address_i[1:0])
      2'd0: begin lane_b = DM_ReadData_i[31:24]; merged[31:24] = StoreData_i[7:0]; end
      2'd1: begin lane_b = DM_ReadData_i[23:16]; merged[23:16] = StoreData_i[7:0]; end
      2'd2: begin lane_b = DM_ReadData_i[15:8];  merged[15:8]  = StoreData_i[7:0]; end
      default: begin lane_b = DM_ReadData_i[7:0]; merged[7:0] = StoreData_i[7:0]; end
    endcase
    lane_h = Address_i[1] ? DM_ReadData_i[15:0] : DM_ReadData_i[31:16];
    if (is_half) begin
      merged = DM_ReadData_i;
      if (Address_i[1]) merged[15:0]  = StoreData_i[15:0];
      else              merged[31:16] = StoreData_i[15:0];
    end
    if (is_byte)      load_ext = {{24{!LoadUnsigned_i && lane_b[7]}}, lane_b};
    else if (is_half) load_ext = {{16{!LoadUnsigned_i && lane_h[15]}}, lane_h};
    else              load_ext = DM_ReadData_i;
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      merged_q    <= '0;
      rmw_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      merged_q    <= merged_d;
      rmw_count_q <= rmw_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    merged_d    = merged_q;
    rmw_count_d = rmw_count_q;
    case (state_q)
      IDLE: if (MemWrite_i && !misaligned && !is_word) begin
        state_d  = RMW_WRITE;
        addr_d   = Address_i;
        merged_d = merged;
      end
      default: begin
        state_d     = IDLE;
        rmw_count_d = rmw_count_q + 16'd1;
      end
    endcase
  end

  always_comb begin
    LoadData_o     = '0;
    Stall_o        = 1'b0;
    AddrError_o    = 1'b0;
    DM_Address_o   = Address_i;
    DM_WriteData_o = StoreData_i;
    DM_MemWrite_o  = 1'b0;
    DM_MemRead_o   = 1'b0;
    if (Rst_i) begin
      DM_Address_o   = '0;
      DM_WriteData_o = '0;
    end else if (state_q == RMW_WRITE) begin
      DM_Address_o   = addr_q;
      DM_WriteData_o = merged_q;
      DM_MemWrite_o  = 1'b1;
    end else if (misaligned) begin
      AddrError_o = 1'b1;
    end else if (MemWrite_i) begin
      // Store wins over a simultaneous read; sub-word stores read first.
      if (is_word) DM_MemWrite_o = 1'b1;
      else begin
        DM_MemRead_o = 1'b1;
        Stall_o      = 1'b1;
      end
    end else if (MemRead_i) begin
      DM_MemRead_o = 1'b1;
      LoadData_o   = load_ext;
    end
  end

  assign RmwCount_o = rmw_count_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory environment plus a byte-level
// reference model of memory contents and the RMW counter.
module tb_load_store_unit;
  logic        Clk = 1'b0, Rst;
  logic [31:0] Address, StoreData, LoadData, DM_Address, DM_WriteData, DM_ReadData;
  logic        MemRead, MemWrite, LoadUnsigned, Stall, AddrError, DM_MemWrite, DM_MemRead;
  logic [1:0]  MemSize;
  logic [15:0] RmwCount;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [15:0] ref_count;
  int checks = 0, errors = 0;

  always #5 Clk = ~Clk;

  load_store_unit dut (
    .Clk_i(Clk), .Rst_i(Rst), .Address_i(Address), .StoreData_i(StoreData),
    .MemRead_i(MemRead), .MemWrite_i(MemWrite), .MemSize_i(MemSize),
    .LoadUnsigned_i(LoadUnsigned), .LoadData_o(LoadData), .Stall_o(Stall),
    .AddrError_o(AddrError), .RmwCount_o(RmwCount), .DM_Address_o(DM_Address),
    .DM_WriteData_o(DM_WriteData), .DM_MemWrite_o(DM_MemWrite),
    .DM_MemRead_o(DM_MemRead), .DM_ReadData_i(DM_ReadData)
  );

  assign DM_ReadData = mem[DM_Address[11:2]];
  always @(posedge Clk) if (DM_MemWrite) mem[DM_Address[11:2]] <= DM_WriteData;

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a[11:2]] = v;
    ref_mem[a[11:2]] = v;
  endtask

  // One pipeline operation, held until the unit lets the pipeline advance.
  task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d, input string tag,
                       output logic [31:0] ld, output int nstall);
    logic word, half, mis;
    logic [31:0] w, exp, mask, lane;
    int idx, sh;
    word = (sz == 2'b00) || (sz == 2'b11);
    half = (sz == 2'b01);
    mis  = (rd || wr) && ((half && a[0]) || (word && a[1:0] != 2'b00));
    idx  = int'(a[11:2]);
    w    = ref_mem[idx];
    mask = half ? 32'hFFFF : 32'hFF;
    sh   = half ? 8 * (2 - int'(a[1:0])) : 8 * (3 - int'(a[1:0]));
    Address = a; StoreData = d; MemRead = rd; MemWrite = wr; MemSize = sz; LoadUnsigned = uns;
    @(negedge Clk);
    ld = LoadData;
    nstall = int'(Stall);
    checks++;
    if (mis) begin
      if ({AddrError, DM_MemRead, DM_MemWrite, Stall, LoadData} !== {4'b1000, 32'h0}) begin
        errors++;
        $display("FAIL %s misaligned: got err/rd/wr/stall/ld=%h expected %h", tag,
                 {AddrError, DM_MemRead, DM_MemWrite, Stall, LoadData}, {4'b1000, 32'h0});
      end
    end else if (wr && word) begin
      if ({AddrError, DM_MemRead, DM_MemWrite, Stall, DM_Address, DM_WriteData} !== {4'b0010, a, d}) begin
        errors++;
        $display("FAIL %s word store: got %h expected %h", tag,
                 {AddrError, DM_MemRead, DM_MemWrite, Stall, DM_Address, DM_WriteData}, {4'b0010, a, d});
      end
      ref_mem[idx] = d;
    end else if (wr) begin
      exp = (w & ~(mask << sh)) | ((d & mask) << sh);
      if ({AddrError, DM_MemRead, DM_MemWrite, Stall, DM_Address} !== {4'b0101, a}) begin
        errors++;
        $display("FAIL %s rmw read cycle: got %h expected %h", tag,
                 {AddrError, DM_MemRead, DM_MemWrite, Stall, DM_Address}, {4'b0101, a});
      end
      @(negedge Clk);
      nstall += int'(Stall);
      checks++;
      if ({AddrError, DM_MemRead, DM_MemWrite, Stall, DM_Address, DM_WriteData, LoadData} !==
          {4'b0010, a, exp, 32'h0}) begin
        errors++;
        $display("FAIL %s rmw write cycle: got %h expected %h", tag,
                 {AddrError, DM_MemRead, DM_MemWrite, Stall, DM_Address, DM_WriteData, LoadData},
                 {4'b0010, a, exp, 32'h0});
      end
      ref_mem[idx] = exp;
      ref_count++;
    end else if (rd) begin
      if (word) exp = w;
      else begin
        lane = (w >> sh) & mask;
        exp  = (!uns && (half ? lane[15] : lane[7])) ? (lane | ~mask) : lane;
      end
      if ({AddrError, DM_MemRead, DM_MemWrite, Stall, DM_Address, LoadData} !== {4'b0100, a, exp}) begin
        errors++;
        $display("FAIL %s load: got %h expected %h", tag,
                 {AddrError, DM_MemRead, DM_MemWrite, Stall, DM_Address, LoadData}, {4'b0100, a, exp});
      end
    end else begin
      if ({AddrError, DM_MemRead, DM_MemWrite, Stall, DM_Address, DM_WriteData, LoadData} !==
          {4'b0000, a, d, 32'h0}) begin
        errors++;
        $display("FAIL %s idle: got %h expected %h", tag,
                 {AddrError, DM_MemRead, DM_MemWrite, Stall, DM_Address, DM_WriteData, LoadData},
                 {4'b0000, a, d, 32'h0});
      end
    end
    @(posedge Clk); #1;
    checks++;
    if ({RmwCount, mem[idx]} !== {ref_count, ref_mem[idx]}) begin
      errors++;
      $display("FAIL %s state after op: got count/word=%h expected %h", tag,
               {RmwCount, mem[idx]}, {ref_count, ref_mem[idx]});
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; Address = 32'h104; StoreData = 32'hFFFF_FFFF;
    MemRead = 1'b1; MemWrite = 1'b1; MemSize = 2'b10; LoadUnsigned = 1'b0;
    @(negedge Clk);
    checks++;
    if ({DM_MemWrite, DM_MemRead, Stall, AddrError, LoadData, DM_Address, DM_WriteData} !== 100'h0) begin
      errors++;
      $display("FAIL reset outputs: got %h expected 0",
               {DM_MemWrite, DM_MemRead, Stall, AddrError, LoadData, DM_Address, DM_WriteData});
    end
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    ref_count = 16'd0;
    checks++;
    if (RmwCount !== 16'd0) begin
      errors++;
      $display("FAIL reset count: got %h expected 0", RmwCount);
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] ld; int ns;
    preload(32'h100, 32'h11223344);
    do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h101, 32'h0000_00AB, "sb", ld, ns);
    checks++;
    if ({ns, mem[32'h40], RmwCount} !== {32'd1, 32'h11AB3344, 16'd1}) begin
      errors++;
      $display("FAIL sb result: got stalls/word/count=%h expected %h",
               {ns, mem[32'h40], RmwCount}, {32'd1, 32'h11AB3344, 16'd1});
    end
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, "lb", ld, ns);
    checks++;
    if (ld !== 32'hFFFF_FFAB) begin errors++; $display("FAIL lb value: got %h expected ffffffab", ld); end
    do_op(1'b1, 1'b0, 2'b10, 1'b1, 32'h101, 32'h0, "lbu", ld, ns);
    checks++;
    if (ld !== 32'h0000_00AB) begin errors++; $display("FAIL lbu value: got %h expected 000000ab", ld); end
  endtask

  task automatic test_half_store();
    logic [31:0] ld; int ns;
    do_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234_BEEF, "sh", ld, ns);
    checks++;
    if ({ns, mem[32'h40]} !== {32'd1, 32'h11ABBEEF}) begin
      errors++;
      $display("FAIL sh result: got %h expected %h", {ns, mem[32'h40]}, {32'd1, 32'h11ABBEEF});
    end
    do_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, "lh", ld, ns);
    checks++;
    if (ld !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh value: got %h expected ffffbeef", ld); end
    do_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, "lhu", ld, ns);
    checks++;
    if (ld !== 32'h0000_11AB) begin errors++; $display("FAIL lhu value: got %h expected 000011ab", ld); end
  endtask

  task automatic test_word();
    logic [31:0] ld; int ns;
    do_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h200, 32'hDEAD_BEEF, "sw", ld, ns);
    checks++;
    if ({ns, RmwCount, mem[32'h80]} !== {32'd0, 16'd2, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL sw result: got %h expected %h", {ns, RmwCount, mem[32'h80]}, {32'd0, 16'd2, 32'hDEADBEEF});
    end
    do_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h200, 32'h0, "lw", ld, ns);
    checks++;
    if (ld !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw value: got %h expected deadbeef", ld); end
  endtask

  task automatic test_misaligned();
    logic [31:0] ld; int ns;
    do_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h103, 32'h0, "lh misaligned", ld, ns);
    checks++;
    if (ld !== 32'h0) begin errors++; $display("FAIL lh misaligned value: got %h expected 0", ld); end
    do_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h202, 32'h1234_5678, "sw misaligned", ld, ns);
    checks++;
    if ({ns, mem[32'h80]} !== {32'd0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL sw misaligned effect: got %h expected %h", {ns, mem[32'h80]}, {32'd0, 32'hDEADBEEF});
    end
  endtask

  task automatic test_reset_mid_rmw();
    Address = 32'h100; StoreData = 32'h55; MemRead = 1'b0; MemWrite = 1'b1;
    MemSize = 2'b10; LoadUnsigned = 1'b0;
    @(negedge Clk);
    checks++;
    if (Stall !== 1'b1) begin errors++; $display("FAIL rst-rmw read stall: got %b expected 1", Stall); end
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if ({DM_MemWrite, DM_MemRead, Stall, AddrError, LoadData, DM_Address, DM_WriteData} !== 100'h0) begin
      errors++;
      $display("FAIL rst-rmw outputs: got %h expected 0",
               {DM_MemWrite, DM_MemRead, Stall, AddrError, LoadData, DM_Address, DM_WriteData});
    end
    @(posedge Clk); #1;
    Rst = 1'b0; MemWrite = 1'b0;
    ref_count = 16'd0;
    checks++;
    if ({RmwCount, mem[32'h40]} !== {16'd0, 32'h11ABBEEF}) begin
      errors++;
      $display("FAIL rst-rmw state: got %h expected %h", {RmwCount, mem[32'h40]}, {16'd0, 32'h11ABBEEF});
    end
    @(negedge Clk);
    checks++;
    if ({DM_MemWrite, DM_MemRead, Stall} !== 3'b000) begin
      errors++;
      $display("FAIL rst-rmw idle after: got %b expected 000", {DM_MemWrite, DM_MemRead, Stall});
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ld; int ns1, ns2;
    preload(32'h300, 32'h0);
    do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h300, 32'h01, "sb b2b first", ld, ns1);
    do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h301, 32'h02, "sb b2b second", ld, ns2);
    checks++;
    if ({ns1, ns2, RmwCount, mem[32'hC0]} !== {32'd1, 32'd1, 16'd2, 32'h01020000}) begin
      errors++;
      $display("FAIL back-to-back: got %h expected %h",
               {ns1, ns2, RmwCount, mem[32'hC0]}, {32'd1, 32'd1, 16'd2, 32'h01020000});
    end
  endtask

  task automatic test_random();
    logic [31:0] ld, a, d; int ns;
    logic rd, wr, uns; logic [1:0] sz;
    for (int i = 0; i < 16; i++) preload(32'h400 + 32'(i * 4), $urandom);
    for (int i = 0; i < 300; i++) begin
      a   = 32'h400 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      d   = $urandom;
      sz  = 2'($urandom_range(0, 3));
      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      do_op(rd, wr, sz, uns, a, d, "random", ld, ns);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    ref_count = 16'd0;
    test_reset();
    test_byte_store();
    test_half_store();
    test_word();
    test_misaligned();
    test_reset_mid_rmw();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
